// File: rtl/cpu_retire_trace_monitor.sv
// cpu_retire_trace_monitor: retirement trace capture with record FIFO, counters and halt/timeout tracking.
// Optional stall watchdog enabled by defining RETIRE_STALL_WDOG_EN.
module cpu_retire_trace_monitor #(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 4,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 100000,
    parameter int STALL_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ret_valid,
    input  logic [2:0]        ret_kind,
    input  logic [DATA_W-1:0] ret_pc,
    input  logic [REG_W-1:0]  ret_reg,
    input  logic [DATA_W-1:0] ret_wdata,
    input  logic [DATA_W-1:0] ret_maddr,
    input  logic [DATA_W-1:0] ret_mdata,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [CNT_W-1:0]  rec_inum,
    output logic [2:0]        rec_kind,
    output logic [DATA_W-1:0] rec_pc,
    output logic [REG_W-1:0]  rec_reg,
    output logic [DATA_W-1:0] rec_wdata,
    output logic [DATA_W-1:0] rec_maddr,
    output logic [DATA_W-1:0] rec_mdata,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted,
    output logic              timeout,
    output logic              overflow,
    output logic              finish
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = CNT_W + 3 + 4 * DATA_W + REG_W;

    typedef enum logic [1:0] {RUN, DRAIN, DONE, TOUT} stateT;

    stateT state, nextState;
    logic [RW-1:0] mem [DEPTH];
    logic [AW:0] wrPtr, rdPtr, wrPtrNext, rdPtrNext;
    logic empty, full, push, pop, accept, isHalt, kindBad, cycTrip, stallTrip, cycInc;
    logic [2:0] kindRec;

    assign accept    = ret_valid && state == RUN;
    assign kindBad   = ret_kind > 3'd4;
    assign kindRec   = kindBad ? 3'd0 : ret_kind;
    assign isHalt    = accept && ret_kind == 3'd4;
    assign empty     = wrPtr == rdPtr;
    assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign pop       = !empty && rec_ready;
    assign push      = accept && (!full || pop);
    assign wrPtrNext = wrPtr + (AW+1)'(push);
    assign rdPtrNext = rdPtr + (AW+1)'(pop);
    assign cycTrip   = cycle_count == CNT_W'(MAX_CYCLES - 1);
    // The timeout edge itself does not count, so cycle_count freezes at MAX_CYCLES-1
    assign cycInc    = (state == DRAIN || (state == RUN && nextState != TOUT)) && ~&cycle_count;

`ifdef RETIRE_STALL_WDOG_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0] stallCnt;
    assign stallTrip = state == RUN && !accept && stallCnt == SW'(STALL_LIMIT - 1);
    always_ff @(posedge clk) begin
        if (rst || accept)
            stallCnt <= '0;
        else if (state == RUN)
            stallCnt <= stallCnt + SW'(1);
    end
`else
    assign stallTrip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= nextState;
    end

    // Halt beats a simultaneous timeout
    always_comb begin
        nextState = state;
        if (state == RUN)
            nextState = isHalt ? DRAIN : (cycTrip || stallTrip) ? TOUT : RUN;
        else if (state == DRAIN && empty)
            nextState = DONE;
    end

    always_comb begin
        halted    = state == DRAIN || state == DONE;
        rec_valid = !empty;
        {rec_inum, rec_kind, rec_pc, rec_reg, rec_wdata, rec_maddr, rec_mdata} =
            rec_valid ? mem[rdPtr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wrPtr[AW-1:0]] <= {inst_count, kindRec, ret_pc, ret_reg, ret_wdata, ret_maddr, ret_mdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            inst_count  <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
            finish      <= 1'b0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
            if (accept && ~&inst_count)
                inst_count <= inst_count + CNT_W'(1);
            if (cycInc)
                cycle_count <= cycle_count + CNT_W'(1);
            if (nextState == TOUT)
                timeout <= 1'b1;
            if (accept && (kindBad || !push))
                overflow <= 1'b1;
            finish <= (nextState == DONE || nextState == TOUT) && wrPtrNext == rdPtrNext;
        end
    end
endmodule
